// File: rtl/fp_subtractor_seq_if.sv
// Handshake/data bundle for fp_subtractor_seq.
//   start      : request, sampled only while the subtractor is idle
//   a, b       : fp32 operands (result is a - b)
//   busy       : operation in flight (accept edge through DONE cycle)
//   done       : one-cycle pulse, out valid in that cycle
//   out        : fp32 result, held until the next done
interface fp_subtractor_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;

  modport master (output start, a, b, input busy, done, out);
  modport slave  (input start, a, b, output busy, done, out);
endinterface

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle fp32 subtractor: out = a - b, computed as a + (-b).
// Serial datapath: align moves Y one bit per cycle, a single add/sub cycle,
// then normalize one bit per cycle. Truncating, denormals flushed to zero.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fp_subtractor_seq_if.slave (start/a/b in, busy/done/out out)
// Latency from the accept edge to the done cycle: min(d,MAX_ALIGN)+n+3 on
// the normal path (n = normalize shifts), 1 for special operands.
module fp_subtractor_seq #(
  parameter int MAX_ALIGN = 25
) (
  input logic                 clk,
  input logic                 rst,
  fp_subtractor_seq_if.slave  bus
);

  localparam int CW = $clog2(MAX_ALIGN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state;
  logic [CW-1:0] cnt;
  logic [23:0] mx, my;
  logic [7:0]  ex;
  logic        sx;
  logic        sub;
  logic [24:0] res;
  logic [31:0] out_r;

  // ---------------- operand unpack (b sign inverted) ----------------
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        za, zb, nan_a, nan_b, inf_a, inf_b;
  logic [23:0] ma, mb;

  assign sa    = bus.a[31];
  assign ea    = bus.a[30:23];
  assign fa    = bus.a[22:0];
  assign sb    = ~bus.b[31];
  assign eb    = bus.b[30:23];
  assign fb    = bus.b[22:0];
  assign za    = (ea == 8'd0);
  assign zb    = (eb == 8'd0);
  assign nan_a = (&ea) && (|fa);
  assign nan_b = (&eb) && (|fb);
  assign inf_a = (&ea) && ~(|fa);
  assign inf_b = (&eb) && ~(|fb);
  assign ma    = za ? 24'd0 : {1'b1, fa};
  assign mb    = zb ? 24'd0 : {1'b1, fb};

  // Special operands bypass the datapath entirely.
  logic        spec;
  logic [31:0] spec_val;
  always_comb begin
    spec     = 1'b1;
    spec_val = 32'd0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) spec_val = 32'h7FC0_0000;
    else if (inf_a)       spec_val = {sa, 8'hFF, 23'd0};
    else if (inf_b)       spec_val = {sb, 8'hFF, 23'd0};
    else if (za && zb)    spec_val = 32'd0;
    else if (za)          spec_val = {sb, bus.b[30:0]};
    else if (zb)          spec_val = bus.a;
    else                  spec     = 1'b0;
  end

  // Magnitude order by {exp, mantissa}; X is the larger operand.
  logic          a_big;
  logic [7:0]    ex_n, ey_n, diff;
  logic [CW-1:0] cnt_load;
  assign a_big    = ({ea, ma} >= {eb, mb});
  assign ex_n     = a_big ? ea : eb;
  assign ey_n     = a_big ? eb : ea;
  assign diff     = ex_n - ey_n;
  assign cnt_load = (diff >= 8'(MAX_ALIGN)) ? CW'(MAX_ALIGN) : CW'(diff);

  // ---------------- add / normalize step ----------------
  // mx >= my after alignment, so the subtract never goes negative.
  logic [24:0] sum;
  logic [24:0] nrm_v, cand_v;
  logic [7:0]  nrm_e, cand_e;
  logic        nrm_ovf, nrm_unf, fin;
  logic [31:0] fin_val;

  always_comb begin
    sum     = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
    nrm_ovf = 1'b0;
    nrm_unf = 1'b0;
    if (res[24]) begin
      nrm_ovf = (ex == 8'hFE);
      nrm_v   = res >> 1;
      nrm_e   = ex + 8'd1;
    end else begin
      nrm_unf = (ex == 8'h01);
      nrm_v   = res << 1;
      nrm_e   = ex - 8'd1;
    end
    // The terminal test looks at the value about to be registered, so a
    // result that is already normalized never spends an extra NORM cycle.
    cand_v  = (state == S_ADD) ? sum : nrm_v;
    cand_e  = (state == S_ADD) ? ex  : nrm_e;
    fin     = (cand_v == 25'd0) || (cand_v[24:23] == 2'b01);
    fin_val = (cand_v == 25'd0) ? 32'd0 : {sx, cand_e, cand_v[22:0]};
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      mx    <= '0;
      my    <= '0;
      ex    <= '0;
      sx    <= 1'b0;
      sub   <= 1'b0;
      res   <= '0;
      out_r <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          if (spec) begin
            out_r <= spec_val;
            state <= S_DONE;
          end else begin
            mx    <= a_big ? ma : mb;
            my    <= a_big ? mb : ma;
            ex    <= ex_n;
            sx    <= a_big ? sa : sb;
            sub   <= (sa != sb);
            cnt   <= cnt_load;
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (cnt != '0) begin
            my  <= my >> 1;
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_ADD;
          end
        end
        S_ADD: begin
          if (fin) begin
            out_r <= fin_val;
            state <= S_DONE;
          end else begin
            res   <= sum;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (nrm_ovf) begin
            out_r <= {sx, 8'hFF, 23'd0};
            state <= S_DONE;
          end else if (nrm_unf) begin
            out_r <= {sx, 31'd0};
            state <= S_DONE;
          end else if (fin) begin
            out_r <= fin_val;
            state <= S_DONE;
          end else begin
            res <= nrm_v;
            ex  <= nrm_e;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.out  = out_r;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
module tb_fp_subtractor_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  fp_subtractor_seq_if bus ();

  fp_subtractor_seq #(.MAX_ALIGN(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stimulus driver only: starts one op at the current cycle, returns the
  // result, the done latency (-1 on timeout) and whether busy held.
  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    res = bus.out;
    if (!bus.done) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tot_cnt++; if (bus.out !== 32'd0) $display("FAIL reset_out got=%h exp=%h", bus.out, 32'd0); else pass_cnt++;
    tot_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    tot_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] r; int l; bit b;
    run_op(32'h40EC0000, 32'h40600000, r, l, b);
    tot_cnt++; if (r !== 32'h40780000) $display("FAIL basic_out got=%h exp=%h", r, 32'h40780000); else pass_cnt++;
    tot_cnt++; if (l !== 5) $display("FAIL basic_lat got=%0d exp=5", l); else pass_cnt++;
    tot_cnt++; if (b !== 1'b1) $display("FAIL basic_busy got=%b exp=1", b); else pass_cnt++;
    tot_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL basic_idle_after busy=%b done=%b exp=0/0", bus.busy, bus.done); else pass_cnt++;
    // negative result, n=0: 1.0 - 3.5 = -2.5
    run_op(32'h3F800000, 32'h40600000, r, l, b);
    tot_cnt++; if (r !== 32'hC0200000) $display("FAIL neg_out got=%h exp=%h", r, 32'hC0200000); else pass_cnt++;
    tot_cnt++; if (l !== 4) $display("FAIL neg_lat got=%0d exp=4", l); else pass_cnt++;
    // effective addition with carry-out: 1.5 - (-1.5) = 3.0
    run_op(32'h3FC00000, 32'hBFC00000, r, l, b);
    tot_cnt++; if (r !== 32'h40400000) $display("FAIL addpath_out got=%h exp=%h", r, 32'h40400000); else pass_cnt++;
    tot_cnt++; if (l !== 4) $display("FAIL addpath_lat got=%0d exp=4", l); else pass_cnt++;
  endtask

  task automatic test_norm_left();
    logic [31:0] r; int l; bit b;
    run_op(32'h3F900000, 32'h3F800000, r, l, b);
    tot_cnt++; if (r !== 32'h3E000000) $display("FAIL norm_out got=%h exp=%h", r, 32'h3E000000); else pass_cnt++;
    tot_cnt++; if (l !== 6) $display("FAIL norm_lat got=%0d exp=6", l); else pass_cnt++;
    run_op(32'h40600000, 32'h40600000, r, l, b);
    tot_cnt++; if (r !== 32'h00000000) $display("FAIL equal_out got=%h exp=%h", r, 32'h0); else pass_cnt++;
    tot_cnt++; if (l !== 3) $display("FAIL equal_lat got=%0d exp=3", l); else pass_cnt++;
  endtask

  task automatic test_align_cap();
    logic [31:0] r; int l; bit b;
    run_op(32'h3F800000, 32'h30800000, r, l, b);
    tot_cnt++; if (r !== 32'h3F800000) $display("FAIL cap_out got=%h exp=%h", r, 32'h3F800000); else pass_cnt++;
    tot_cnt++; if (l !== 28) $display("FAIL cap_lat got=%0d exp=28", l); else pass_cnt++;
    // d=23 below the cap: 1.0 - 2^-23 = 0x3F7FFFFE after truncation
    run_op(32'h3F800000, 32'h34000000, r, l, b);
    tot_cnt++; if (r !== 32'h3F7FFFFE) $display("FAIL d23_out got=%h exp=%h", r, 32'h3F7FFFFE); else pass_cnt++;
    tot_cnt++; if (l !== 27) $display("FAIL d23_lat got=%0d exp=27", l); else pass_cnt++;
  endtask

  task automatic test_specials();
    logic [31:0] av [7];
    logic [31:0] bv [7];
    logic [31:0] ev [7];
    logic [31:0] r; int l; bit b;
    av = '{32'h7F800000, 32'h7F800000, 32'h00000000, 32'h7F800001, 32'h80000000, 32'h40600000, 32'h00000001};
    bv = '{32'h7F800000, 32'hFE000000, 32'h40600000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h40600000};
    ev = '{32'h7FC00000, 32'h7F800000, 32'hC0600000, 32'h7FC00000, 32'h00000000, 32'h40600000, 32'hC0600000};
    for (int i = 0; i < 7; i++) begin
      run_op(av[i], bv[i], r, l, b);
      tot_cnt++; if (r !== ev[i]) $display("FAIL special%0d_out got=%h exp=%h", i, r, ev[i]); else pass_cnt++;
      tot_cnt++; if (l !== 1) $display("FAIL special%0d_lat got=%0d exp=1", i, l); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int l; bit b;
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF, r, l, b);
    tot_cnt++; if (r !== 32'h7F800000) $display("FAIL ovf_out got=%h exp=%h", r, 32'h7F800000); else pass_cnt++;
    // exponent would drop to 0 while normalizing -> +0
    run_op(32'h00C00000, 32'h00800000, r, l, b);
    tot_cnt++; if (r !== 32'h00000000) $display("FAIL unf_out got=%h exp=%h", r, 32'h0); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int l; bit stray;
    bus.a = 32'h40EC0000; bus.b = 32'h40600000; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; l = 1;
    @(posedge clk); #1; l++;
    bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; l++;
    while (!bus.done && l < 100) begin @(posedge clk); #1; l++; end
    tot_cnt++; if (bus.out !== 32'h40780000) $display("FAIL busy_ign_out got=%h exp=%h", bus.out, 32'h40780000); else pass_cnt++;
    tot_cnt++; if (l !== 5) $display("FAIL busy_ign_lat got=%0d exp=5", l); else pass_cnt++;
    // start during the DONE cycle must not be accepted
    bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    tot_cnt++; if (bus.busy !== 1'b0) $display("FAIL done_start_busy got=%b exp=0", bus.busy); else pass_cnt++;
    stray = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (bus.done || bus.busy) stray = 1'b1; end
    tot_cnt++; if (stray !== 1'b0) $display("FAIL done_start_stray got=%b exp=0", stray); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int l; bit b, seen;
    bus.a = 32'h40EC0000; bus.b = 32'h40600000; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    tot_cnt++; if (bus.out !== 32'd0) $display("FAIL rstmid_out got=%h exp=%h", bus.out, 32'd0); else pass_cnt++;
    tot_cnt++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", bus.busy); else pass_cnt++;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    tot_cnt++; if (seen !== 1'b0) $display("FAIL rstmid_nodone got=%b exp=0", seen); else pass_cnt++;
    run_op(32'h40EC0000, 32'h40600000, r, l, b);
    tot_cnt++; if (r !== 32'h40780000) $display("FAIL rstmid_rerun_out got=%h exp=%h", r, 32'h40780000); else pass_cnt++;
    tot_cnt++; if (l !== 5) $display("FAIL rstmid_rerun_lat got=%0d exp=5", l); else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_norm_left();
    test_align_cap();
    test_specials();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
